// File: rtl/iact_skew_feeder.sv
// iact_skew_feeder
//   Buffers activation vectors in a small FIFO and feeds them to a PE array
//   with a diagonal skew: row r of a popped vector leaves r+1 advancing
//   cycles after the pop. Each tile ends with a vector flagged last. After
//   that pop the feeder stops popping until the skew has drained, then
//   pulses done.
// Parameters: ROWS (PE rows, 2..16), DATA_W (activation width),
//   DEPTH (FIFO depth, power of two >= 2)
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last   vector input handshake
//   advance          array enable; everything holds when low
//   out_iact/out_valid  skewed activations and per-row qualifiers
//   busy, done       tile in progress / one-cycle drain-complete pulse
//   stall_cnt        (only with FEEDER_STALL_CNT_EN) starved STREAM cycles
// Build option: define FEEDER_STALL_CNT_EN to add the stall_cnt output.

// One skew row: a LEN-deep shift chain of data plus its valid bit.
module iact_skew_row #(
  parameter int LEN    = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              v_i,
  output logic [DATA_W-1:0] d_o,
  output logic              v_o
);
  logic [LEN-1:0][DATA_W-1:0] dat_q;
  logic [LEN-1:0]             vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q <= '0;
      vld_q <= '0;
    end else if (en_i) begin
      dat_q[0] <= d_i;
      vld_q[0] <= v_i;
      for (int i = 1; i < LEN; i++) begin
        dat_q[i] <= dat_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign d_o = dat_q[LEN-1];
  assign v_o = vld_q[LEN-1];
endmodule

module iact_skew_feeder #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  input  logic                   in_last,
  input  logic                   advance,
  output logic [ROWS*DATA_W-1:0] out_iact,
  output logic [ROWS-1:0]        out_valid,
  output logic                   busy,
`ifdef FEEDER_STALL_CNT_EN
  output logic [15:0]            stall_cnt,
`endif
  output logic                   done
);
  localparam int AW  = $clog2(DEPTH);
  localparam int DCW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  typedef struct packed {
    logic                         last;
    logic [ROWS-1:0][DATA_W-1:0]  data;
  } ent_t;

  ent_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  state_t            state_q;
  logic [DCW-1:0]    drain_cnt_q;
  logic              busy_q, done_q;

  logic full, empty, push, pop, drain_end;
  ent_t pop_ent, push_ent;
  logic [ROWS-1:0][DATA_W-1:0] feed_data, row_dat;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  // No push while full, even if a pop frees a slot this cycle.
  assign in_ready  = !full && (state_q != DRAIN);
  assign push      = in_valid && in_ready;
  assign pop       = advance && !empty && (state_q != DRAIN);
  assign pop_ent   = mem_q[rd_ptr_q];
  assign push_ent  = '{last: in_last, data: in_data};
  assign drain_end = (state_q == DRAIN) && advance && (drain_cnt_q == DCW'(1));

  // Bubbles (zero data, valid low) enter whenever the array advances without a pop.
  assign feed_data = pop ? pop_ent.data : '0;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Tile FSM. An entry queued behind a last vector is popped once back in
  // IDLE, which starts the next tile without needing a fresh push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, STREAM: begin
          if (pop && pop_ent.last) begin
            state_q     <= DRAIN;
            drain_cnt_q <= DCW'(ROWS);
            busy_q      <= 1'b1;
          end else if (state_q == IDLE && (push || pop)) begin
            state_q <= STREAM;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (advance) begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    iact_skew_row #(.LEN(r + 1), .DATA_W(DATA_W)) u_row (
      .clk  (clk),
      .rst  (rst),
      .en_i (advance),
      .d_i  (feed_data[r]),
      .v_i  (pop),
      .d_o  (row_dat[r]),
      .v_o  (out_valid[r])
    );
  end

  assign out_iact = row_dat;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  // Cleared on the same edge that raises done, so it reads 0 from the pulse on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (drain_end)
      stall_q <= '0;
    else if (state_q == STREAM && advance && empty && stall_q != 16'hFFFF)
      stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_iact_skew_feeder.sv
module tb_iact_skew_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        advance;
  logic [63:0] out_iact;
  logic [3:0]  out_valid;
  logic        busy;
  logic        done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  iact_skew_feeder #(.ROWS(4), .DATA_W(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .advance   (advance),
    .out_iact  (out_iact),
    .out_valid (out_valid),
    .busy      (busy),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] row(input int r);
    return out_iact[r*16 +: 16];
  endfunction

  function automatic logic [63:0] pk(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // One last-flagged vector with advance held high: push in c0, pop in c1,
  // row r visible in c2+r, done in c6.
  task automatic single_vec(input logic [15:0] a, b, c, d);
    advance = 1; in_valid = 1; in_data = pk(a, b, c, d); in_last = 1;
    chk("sv_ready", in_ready, 1);
    tick();
    in_valid = 0; in_last = 0;
    chk("sv_busy", busy, 1);
    chk("sv_v_pop", out_valid, 4'b0000);
    tick();
    chk("sv_v1", out_valid, 4'b0001); chk("sv_r0", row(0), a);
    tick();
    chk("sv_v2", out_valid, 4'b0010); chk("sv_r1", row(1), b); chk("sv_r0b", row(0), 0);
    tick();
    chk("sv_v3", out_valid, 4'b0100); chk("sv_r2", row(2), c);
    tick();
    chk("sv_v4", out_valid, 4'b1000); chk("sv_r3", row(3), d); chk("sv_done_early", done, 0);
    tick();
    chk("sv_done", done, 1); chk("sv_busy_end", busy, 0); chk("sv_v5", out_valid, 4'b0000);
    tick();
    chk("sv_done_1cyc", done, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_last = 0; advance = 0;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_iact", out_iact, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 1);
`ifdef FEEDER_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    tick();
    rst = 0;
    tick();

    // Single vector
    single_vec(16'd1, 16'd2, 16'd3, 16'd4);

    // Back-to-back vectors, second one last
    advance = 1; in_valid = 1; in_data = pk(10, 20, 30, 40); in_last = 0;
    tick();                                                     // c1
    in_data = pk(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC); in_last = 1;
    tick();                                                     // c2
    in_valid = 0; in_last = 0;
    chk("b2b_r0_a", row(0), 10);
    tick();                                                     // c3
    chk("b2b_r0_b", row(0), 16'hFFFF); chk("b2b_v0_b", out_valid[0], 1);
    chk("b2b_drain_ready", in_ready, 0);
    tick();                                                     // c4
    chk("b2b_r0_bub", row(0), 0); chk("b2b_v0_bub", out_valid[0], 0);
    tick();                                                     // c5
    chk("b2b_r3_a", row(3), 40); chk("b2b_v3_a", out_valid[3], 1);
    tick();                                                     // c6
    chk("b2b_r3_b", row(3), 16'hFFFC); chk("b2b_v3_b", out_valid[3], 1);
    tick();                                                     // c7
    chk("b2b_done", done, 1);
    tick();

    // FIFO full backpressure with advance low
    advance = 0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_last = 0;
      in_data = pk(16'(i*16), 16'(i*16+1), 16'(i*16+2), 16'(i*16+3));
      chk("full_ready_fill", in_ready, 1);
      tick();
    end
    in_data = pk(80, 81, 82, 83); in_last = 1;                 // c4
    chk("full_ready_c4", in_ready, 0);
    tick();                                                     // c5
    chk("full_ready_c5", in_ready, 0);
    tick();                                                     // c6
    advance = 1;
    chk("full_ready_adv", in_ready, 0);
    tick();                                                     // c7: v5 accepted
    chk("full_ready_c7", in_ready, 1);
    chk("full_r0_v1", row(0), 16);
    tick();                                                     // c8
    in_valid = 0; in_last = 0;
    chk("full_r0_v2", row(0), 32);
    for (int i = 0; i < 6; i++) tick();                         // c14
    chk("full_r3_v5", row(3), 83); chk("full_done_early", done, 0);
    tick();                                                     // c15
    chk("full_done", done, 1);
    tick();

    // advance 1,0,1 slips every row by one cycle
    advance = 1; in_valid = 1; in_data = pk(1, 2, 3, 4); in_last = 1;
    tick();                                                     // c1
    in_valid = 0; in_last = 0;
    tick();                                                     // c2
    chk("hold_r0", row(0), 1);
    tick();                                                     // c3
    advance = 0;
    chk("hold_v_c3", out_valid, 4'b0010); chk("hold_r1_c3", row(1), 2);
    tick();                                                     // c4
    advance = 1;
    chk("hold_v_c4", out_valid, 4'b0010); chk("hold_r1_c4", row(1), 2);
    tick();                                                     // c5
    chk("hold_v_c5", out_valid, 4'b0100); chk("hold_r2", row(2), 3);
    tick();                                                     // c6
    chk("hold_v_c6", out_valid, 4'b1000); chk("hold_r3", row(3), 4);
    chk("hold_done_early", done, 0);
    tick();                                                     // c7
    chk("hold_done", done, 1);
    tick();

    // Reset during DRAIN
    advance = 1; in_valid = 1; in_data = pk(5, 6, 7, 8); in_last = 1;
    tick();                                                     // c1 pop
    in_valid = 0; in_last = 0;
    tick();                                                     // c2 DRAIN
    tick();                                                     // c3
    chk("mid_busy_pre", busy, 1);
    rst = 1;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_iact", out_iact, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    tick();
    rst = 0;
    tick();
    chk("mid_no_done", done, 0);
    single_vec(16'd7, 16'd7, 16'd7, 16'd7);

`ifdef FEEDER_STALL_CNT_EN
    // Three empty STREAM cycles (c2..c4) before the last vector
    advance = 1; in_valid = 1; in_data = pk(1, 1, 1, 1); in_last = 0;
    tick();                                                     // c1 pop
    in_valid = 0;
    tick(); tick();                                             // c3
    tick();                                                     // c4
    in_valid = 1; in_data = pk(2, 2, 2, 2); in_last = 1;
    tick();                                                     // c5 pop last
    in_valid = 0; in_last = 0;
    chk("stall_c5", stall_cnt, 3);
    for (int i = 0; i < 4; i++) tick();                         // c9
    chk("stall_pre_done", stall_cnt, 3); chk("stall_done_early", done, 0);
    tick();                                                     // c10
    chk("stall_done", done, 1); chk("stall_clr", stall_cnt, 0);
    tick();
    chk("stall_after", stall_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iact_skew_feeder.md
IACT_SKEW_FEEDER -- requirements
Module: iact_skew_feeder

Interface
REQ-001 The module SHALL have parameter ROWS, default 4, number of PE rows fed (legal 2..16).
REQ-002 The module SHALL have parameter DATA_W, default 16, signed activation width matching the PE iact port.
REQ-003 The module SHALL have parameter DEPTH, default 4, input vector FIFO depth (power of two, >=2).
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; one clock; reset is asynchronous and active-high.
REQ-005 The module SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit, an activation vector is offered.
REQ-007 The module SHALL have port in_ready, output, 1 bit, the vector is accepted this cycle.
REQ-008 The module SHALL have port in_data, input, ROWS*DATA_W bits, signed activations, row r in bits [r*DATA_W +: DATA_W].
REQ-009 The module SHALL have port in_last, input, 1 bit, marks the final vector of a tile.
REQ-010 The module SHALL have port advance, input, 1 bit, array enable; when 0 the feeder holds.
REQ-011 The module SHALL have port out_iact, output, ROWS*DATA_W bits, skewed activations to the PE row iact_in ports, same packing as in_data.
REQ-012 The module SHALL have port out_valid, output, ROWS bits, per-row qualifier for out_iact.
REQ-013 The module SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-014 The module SHALL have port done, output, 1 bit, one-cycle pulse when the skew is fully drained.

Function
REQ-015 A vector with its last flag SHALL be written to the FIFO on in_valid && in_ready; in_ready = !full && state != DRAIN.
REQ-016 A push while full SHALL NOT occur, even when a pop happens in the same cycle; a push and pop together while not full SHALL both take effect.
REQ-017 A pop SHALL occur on advance && !empty && state != DRAIN; the earliest pop is the cycle after the push (FIFO registered, no fall-through).
REQ-018 Skew: element r of a popped vector SHALL appear on out_iact row r with out_valid[r]=1 exactly 1+r advancing cycles after the pop.
REQ-019 Each row SHALL be a shift chain of r+1 registers that shifts only when advance=1 and holds otherwise.
REQ-020 On advance=1 with the FIFO empty, a bubble SHALL enter: data 0 with valid 0, so that a PE product adds 0 to psum.
REQ-021 State machine: IDLE -> STREAM on the first push; STREAM -> DRAIN when the popped entry has last=1, with drain_cnt loaded to ROWS.
REQ-022 In DRAIN, each advance SHALL decrement drain_cnt; when it reaches 0, done SHALL pulse for 1 cycle and the state SHALL return to IDLE.
REQ-023 A vector waiting in the FIFO behind a last entry SHALL stay queued until IDLE and then start a new tile.
REQ-024 Data SHALL pass unmodified, with no arithmetic and no sign change.

Reset
REQ-025 rst=1 SHALL asynchronously clear the FIFO pointers and count, all skew registers, out_iact, out_valid, done, busy and drain_cnt, and set the state to IDLE; in_ready SHALL be 1 after reset.
REQ-026 Reset mid-tile SHALL discard all in-flight data and SHALL NOT pulse done.

Configuration
REQ-027 When macro FEEDER_STALL_CNT_EN is defined, the module SHALL add output stall_cnt, 16 bits, which counts cycles in STREAM with advance=1 and the FIFO empty, saturates at 16'hFFFF, and clears on rst and on the done pulse.
REQ-028 When FEEDER_STALL_CNT_EN is undefined, the stall_cnt port and its logic SHALL be absent, with no other behaviour change.

Verification (ROWS=4, DEPTH=4, DATA_W=16)
REQ-029 Single vector {1,2,3,4} with last=1 and advance=1 SHALL give row0=1 at pop+1, row1=2 at pop+2, row2=3 at pop+3, row3=4 at pop+4; done SHALL pulse at pop+5.
REQ-030 Back-to-back vectors {10,20,30,40} and {-1,-2,-3,-4} (last) SHALL make row3 show 40 then -4 on consecutive cycles, and row0 SHALL show 0/valid 0 after -1.
REQ-031 Pushing 5 vectors with advance=0 SHALL drop in_ready after the 4th; the 5th SHALL be accepted the cycle after advance rises.
REQ-032 advance toggling 1,0,1 mid-stream SHALL hold out_iact/out_valid during the 0 cycle, and every row SHALL slip by exactly 1 cycle.
REQ-033 Asserting rst during DRAIN SHALL immediately zero out_valid, out_iact, busy and done, and the following vector {7,7,7,7} SHALL behave as in REQ-029.
REQ-034 With FEEDER_STALL_CNT_EN defined, a 3-cycle FIFO-empty gap in STREAM with advance=1 SHALL make stall_cnt=3 before done and 0 after it.
